mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- N-channel arbiter between CPU-side requesters (icache, LSB, spare/prefetch) and the single byte-serial memory unit.
- Replaces fixed data-over-inst muxing with a registered grant, fixed or round-robin priority, and one-transaction-at-a-time ownership.
- Flush-aware: reads from flushable channels are discarded on `rob_clear`.

Parameters:
- NUM_PORTS, 3, number of requester channels; channel 0 = instruction fetch by convention.
- RR_MODE, 1, 1 = round-robin starting after the last grantee; 0 = fixed priority, highest index wins.
- FLUSH_MASK, 3'b001, bit i set = channel i's reads are discarded on `rob_clear`.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- rob_clear  in  1  pipeline flush pulse
- req_valid  in  NUM_PORTS  per-channel request, held until that channel's resp_ready
- req_wr  in  NUM_PORTS  1 = write
- req_len  in  3*NUM_PORTS  [2] unsigned, [1:0] 00 byte / 01 half / 10 word
- req_addr  in  ADDR_W*NUM_PORTS  per-channel address
- req_value  in  DATA_W*NUM_PORTS  per-channel write data
- resp_ready  out  NUM_PORTS  one-cycle completion pulse, one-hot
- resp_result  out  DATA_W  read data, valid while resp_ready is nonzero
- mu_valid  out  1  request to memory unit
- mu_wr  out  1  to memory unit
- mu_len  out  3  to memory unit
- mu_addr  out  ADDR_W  to memory unit
- mu_value  out  DATA_W  to memory unit
- mu_result  in  DATA_W  from memory unit
- mu_ready  in  1  memory unit done, one cycle

Behaviour:
- Reset (rst_in=1 at posedge): state=IDLE; grant=0; last=NUM_PORTS-1; discard=0; all outputs 0 except mu_len=3'b111. Reset overrides rdy_in and aborts any transaction mid-flight.
- When rdy_in=0 and not in reset, every register holds and outputs keep their values.
- IDLE state:
  - If any req_valid bit is set, select a winner:
    - RR_MODE=1: first set bit scanning last+1, last+2, …, with wrap-around modulo NUM_PORTS.
    - RR_MODE=0: highest set index.
  - Register grant=winner, latch that channel's wr/len/addr/value into command registers, go to BUSY.
  - If rob_clear=1 in the same cycle, winners that are flushable reads are ignored: they do not win, and arbitration uses the remaining bits.
- BUSY state:
  - mu_valid=1; mu_* driven from the command registers, stable for the whole transaction.
  - rob_clear=1 while the grant is a flushable read sets discard=1. The memory transaction is never aborted.
  - rob_clear never affects writes or non-flushable channels.
  - When mu_ready=1: latch mu_result into the result register, set last=grant, go to DONE.
- DONE state (exactly one cycle):
  - mu_valid=0.
  - If discard=0: resp_ready[grant]=1 and resp_result=the latched value.
  - If discard=1: resp_ready=0.
  - Next state IDLE; discard cleared.
- In IDLE and BUSY, resp_ready=0 and resp_result=0.
- Latency: request sampled in cycle t → mu_valid from t+1 → mu_ready at t+1+M → resp_ready at t+2+M, where M is the memory-unit latency.
- Next arbitration happens in IDLE, one cycle after DONE. A requester that drops valid on resp_ready is therefore never re-granted for that request.
- Discarded requesters must deassert or re-issue themselves. If valid is still high in IDLE, the request is treated as new.
- mu_valid is never high in IDLE or DONE. At most one channel holds a grant at any time.
- Changes to req_* on the granted channel during BUSY are ignored, because the command is latched.

Test Plan:
- Single read: ch1 valid, addr=0x1000, len=010; memory unit returns 0xDEADBEEF after 4 cycles → mu_addr=0x1000 held for 4 cycles; resp_ready=3'b010 with resp_result=0xDEADBEEF exactly one cycle after mu_ready.
- Round-robin fairness (RR_MODE=1): ch0/1/2 all held valid, each dropping valid on its own resp_ready then reasserting → grant order 0,1,2,0,1,2. With RR_MODE=0 → ch2 is served first, then ch1, then ch0.
- Flush during fetch: ch0 read granted, rob_clear pulses mid-BUSY → mu_valid held until mu_ready; resp_ready stays 0; next ch1 request is served normally.
- Flush does not touch stores: ch1 write addr=0x30000 value=0x41, rob_clear mid-BUSY → mu_wr=1 for the full transaction; resp_ready[1] pulses.
- rdy_in stall: rdy_in=0 for 3 cycles mid-BUSY → state and mu_* unchanged; completion delayed exactly 3 cycles.
- Reset mid-BUSY: rst_in=1 for one cycle → all outputs at reset values next cycle; ch2 request after reset is granted first via the wrapped scan from last=2.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU-side requesters, the arbiter and the memory unit.
// Ports:
//   req_valid/req_wr/req_len/req_addr/req_value : per-channel request, flattened per channel
//   resp_ready/resp_result                      : one-hot completion pulse and read data
//   mu_valid/mu_wr/mu_len/mu_addr/mu_value      : command to the memory unit
//   mu_result/mu_ready                          : memory unit return data and done pulse
// Modports: slave = arbiter view, master = requester/memory-unit view.
interface mem_arbiter_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_wr;
    logic [3*NUM_PORTS-1:0]      req_len;
    logic [ADDR_W*NUM_PORTS-1:0] req_addr;
    logic [DATA_W*NUM_PORTS-1:0] req_value;
    logic [NUM_PORTS-1:0]        resp_ready;
    logic [DATA_W-1:0]           resp_result;
    logic                        mu_valid;
    logic                        mu_wr;
    logic [2:0]                  mu_len;
    logic [ADDR_W-1:0]           mu_addr;
    logic [DATA_W-1:0]           mu_value;
    logic [DATA_W-1:0]           mu_result;
    logic                        mu_ready;

    modport slave (
        input  req_valid, req_wr, req_len, req_addr, req_value,
        output resp_ready, resp_result,
        output mu_valid, mu_wr, mu_len, mu_addr, mu_value,
        input  mu_result, mu_ready
    );

    modport master (
        output req_valid, req_wr, req_len, req_addr, req_value,
        input  resp_ready, resp_result,
        input  mu_valid, mu_wr, mu_len, mu_addr, mu_value,
        output mu_result, mu_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter in front of the single byte-serial memory unit.
// One transaction at a time: IDLE arbitrates, BUSY owns the memory unit, DONE pulses
// the one-hot response. Reads on flushable channels are dropped on rob_clear.
// Ports:
//   clk_in    : system clock
//   rst_in    : synchronous active-high reset
//   rdy_in    : global enable, low freezes every register
//   rob_clear : pipeline flush pulse
//   bus       : request/response/memory-unit bundle (slave view)
module mem_arbiter #(
    parameter int unsigned          NUM_PORTS  = 3,
    parameter bit                   RR_MODE    = 1'b1,
    parameter logic [NUM_PORTS-1:0] FLUSH_MASK = NUM_PORTS'(3'b001),
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          DATA_W     = 32
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         rob_clear,
    mem_arbiter_if.slave bus
);
    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [GW-1:0]         r_grant, w_grant_nxt;
    logic [GW-1:0]         r_last, w_last_nxt;
    logic                  r_discard, w_discard_nxt;
    logic                  r_cmd_wr, w_cmd_wr_nxt;
    logic [2:0]            r_cmd_len, w_cmd_len_nxt;
    logic [ADDR_W-1:0]     r_cmd_addr, w_cmd_addr_nxt;
    logic [DATA_W-1:0]     r_cmd_value, w_cmd_value_nxt;
    logic                  r_mu_valid, w_mu_valid_nxt;
    logic [NUM_PORTS-1:0]  r_resp_ready, w_resp_ready_nxt;
    logic [DATA_W-1:0]     r_resp_result, w_resp_result_nxt;

    logic [NUM_PORTS-1:0]  w_elig;
    logic                  w_found;
    logic [GW-1:0]         w_win;
    logic                  w_flush_rd;

    // Winner selection; flushable reads are masked out while rob_clear is high
    always_comb begin
        w_elig  = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            w_elig[i] = bus.req_valid[i] & ~(rob_clear & FLUSH_MASK[i] & ~bus.req_wr[i]);
        end
        if (RR_MODE) begin
            // scan last+1, last+2, ... with wrap-around
            for (int k = 1; k <= int'(NUM_PORTS); k++) begin
                int idx;
                idx = (int'(r_last) + k) % int'(NUM_PORTS);
                if (!w_found && w_elig[idx]) begin
                    w_found = 1'b1;
                    w_win   = GW'(idx);
                end
            end
        end else begin
            // later (higher) index overrides, so the highest set bit wins
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (w_elig[i]) begin
                    w_found = 1'b1;
                    w_win   = GW'(i);
                end
            end
        end
    end

    assign w_flush_rd = FLUSH_MASK[r_grant] & ~r_cmd_wr;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
            S_BUSY:  if (bus.mu_ready) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values, registered below
    always_comb begin
        w_grant_nxt       = r_grant;
        w_last_nxt        = r_last;
        w_discard_nxt     = r_discard;
        w_cmd_wr_nxt      = r_cmd_wr;
        w_cmd_len_nxt     = r_cmd_len;
        w_cmd_addr_nxt    = r_cmd_addr;
        w_cmd_value_nxt   = r_cmd_value;
        w_mu_valid_nxt    = (w_state_nxt == S_BUSY);
        w_resp_ready_nxt  = '0;
        w_resp_result_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt     = w_win;
                    w_discard_nxt   = 1'b0;
                    w_cmd_wr_nxt    = bus.req_wr[w_win];
                    w_cmd_len_nxt   = bus.req_len[3*int'(w_win) +: 3];
                    w_cmd_addr_nxt  = bus.req_addr[ADDR_W*int'(w_win) +: ADDR_W];
                    w_cmd_value_nxt = bus.req_value[DATA_W*int'(w_win) +: DATA_W];
                end
            end
            S_BUSY: begin
                if (rob_clear && w_flush_rd) begin
                    w_discard_nxt = 1'b1;
                end
                if (bus.mu_ready) begin
                    w_last_nxt = r_grant;
                    if (!w_discard_nxt) begin
                        w_resp_ready_nxt  = NUM_PORTS'(1) << r_grant;
                        w_resp_result_nxt = bus.mu_result;
                    end
                end
            end
            S_DONE: begin
                w_discard_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_grant       <= '0;
            r_last        <= GW'(NUM_PORTS - 1);
            r_discard     <= 1'b0;
            r_cmd_wr      <= 1'b0;
            r_cmd_len     <= 3'b111;
            r_cmd_addr    <= '0;
            r_cmd_value   <= '0;
            r_mu_valid    <= 1'b0;
            r_resp_ready  <= '0;
            r_resp_result <= '0;
        end else if (rdy_in) begin
            r_grant       <= w_grant_nxt;
            r_last        <= w_last_nxt;
            r_discard     <= w_discard_nxt;
            r_cmd_wr      <= w_cmd_wr_nxt;
            r_cmd_len     <= w_cmd_len_nxt;
            r_cmd_addr    <= w_cmd_addr_nxt;
            r_cmd_value   <= w_cmd_value_nxt;
            r_mu_valid    <= w_mu_valid_nxt;
            r_resp_ready  <= w_resp_ready_nxt;
            r_resp_result <= w_resp_result_nxt;
        end
    end

    assign bus.mu_valid    = r_mu_valid;
    assign bus.mu_wr       = r_cmd_wr;
    assign bus.mu_len      = r_cmd_len;
    assign bus.mu_addr     = r_cmd_addr;
    assign bus.mu_value    = r_cmd_value;
    assign bus.resp_ready  = r_resp_ready;
    assign bus.resp_result = r_resp_result;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench: a round-robin instance and a fixed-priority instance.
module tb_mem_arbiter;
    logic clk;
    logic rst_in;
    logic rdy_in;
    logic rob_clear;
    int   total;
    int   bad;

    mem_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) bus_rr ();
    mem_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) bus_fp ();

    mem_arbiter #(.NUM_PORTS(3), .RR_MODE(1'b1), .FLUSH_MASK(3'b001), .ADDR_W(32), .DATA_W(32)) dut_rr (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear), .bus(bus_rr.slave));
    mem_arbiter #(.NUM_PORTS(3), .RR_MODE(1'b0), .FLUSH_MASK(3'b001), .ADDR_W(32), .DATA_W(32)) dut_fp (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear), .bus(bus_fp.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
    endtask

    task automatic set_req(input bit fp, input int ch, input logic v, input logic wr,
                           input logic [2:0] len, input logic [31:0] addr, input logic [31:0] val);
        if (fp) begin
            bus_fp.req_valid[ch] = v;  bus_fp.req_wr[ch] = wr;  bus_fp.req_len[3*ch +: 3] = len;
            bus_fp.req_addr[32*ch +: 32] = addr;  bus_fp.req_value[32*ch +: 32] = val;
        end else begin
            bus_rr.req_valid[ch] = v;  bus_rr.req_wr[ch] = wr;  bus_rr.req_len[3*ch +: 3] = len;
            bus_rr.req_addr[32*ch +: 32] = addr;  bus_rr.req_value[32*ch +: 32] = val;
        end
    endtask

    task automatic set_mu(input bit fp, input logic rdy, input logic [31:0] data);
        if (fp) begin bus_fp.mu_ready = rdy; bus_fp.mu_result = data; end
        else    begin bus_rr.mu_ready = rdy; bus_rr.mu_result = data; end
    endtask

    function automatic logic mv(input bit fp);
        return fp ? bus_fp.mu_valid : bus_rr.mu_valid;
    endfunction

    // Memory-unit stand-in: wait for mu_valid, answer after lat cycles of mu_valid
    task automatic serve(input bit fp, input int lat, input logic [31:0] data, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            if (mv(fp)) ok = 1'b1;
            else cyc();
        end
        if (ok) begin
            for (int i = 1; i < lat; i++) cyc();
            set_mu(fp, 1'b1, data);
            cyc();
            set_mu(fp, 1'b0, 32'h0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus_rr.mu_valid !== 1'b0 || bus_rr.mu_len !== 3'b111 || bus_rr.mu_addr !== 32'h0 ||
            bus_rr.mu_wr !== 1'b0 || bus_rr.mu_value !== 32'h0 || bus_rr.resp_ready !== 3'b000 ||
            bus_rr.resp_result !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b len=%b addr=%h wr=%b val=%h rr=%b res=%h, need 0/111/0/0/0/000/0",
                     bus_rr.mu_valid, bus_rr.mu_len, bus_rr.mu_addr, bus_rr.mu_wr, bus_rr.mu_value,
                     bus_rr.resp_ready, bus_rr.resp_result);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(0, 1, 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus_rr.mu_valid !== 1'b1 || bus_rr.mu_addr !== 32'h1000 || bus_rr.mu_len !== 3'b010 ||
                bus_rr.resp_ready !== 3'b000) begin
                bad++;
                $display("FAIL single_busy[%0d]: got valid=%b addr=%h len=%b rr=%b, need 1/00001000/010/000",
                         i, bus_rr.mu_valid, bus_rr.mu_addr, bus_rr.mu_len, bus_rr.resp_ready);
            end
            if (i == 1) bus_rr.req_addr[63:32] = 32'hBAD0;
            if (i == 3) set_mu(0, 1'b1, 32'hDEADBEEF);
            cyc();
        end
        set_mu(0, 1'b0, 32'h0);
        total++;
        if (bus_rr.resp_ready !== 3'b010 || bus_rr.resp_result !== 32'hDEADBEEF || bus_rr.mu_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_done: got rr=%b res=%h valid=%b, need 010/deadbeef/0",
                     bus_rr.resp_ready, bus_rr.resp_result, bus_rr.mu_valid);
        end
        set_req(0, 1, 1'b0, 1'b0, 3'b010, 32'h1000, 32'h0);
        cyc();
        total++;
        if (bus_rr.resp_ready !== 3'b000 || bus_rr.resp_result !== 32'h0) begin
            bad++;
            $display("FAIL single_after: got rr=%b res=%h, need 000/0", bus_rr.resp_ready, bus_rr.resp_result);
        end
        cyc();
    endtask

    task automatic test_rr_fairness();
        bit ok;
        int exp;
        do_reset();
        for (int c = 0; c < 3; c++) set_req(0, c, 1'b1, 1'b0, 3'b010, 32'h100 * (c + 1), 32'h0);
        for (int r = 0; r < 6; r++) begin
            exp = r % 3;
            serve(0, 2, 32'hA0 + r, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL rr_timeout[%0d]: got no mu_valid, need mu_valid", r); end
            total++;
            if (bus_rr.resp_ready !== 3'(1 << exp) || bus_rr.resp_result !== 32'hA0 + r ||
                bus_rr.mu_addr !== 32'h100 * (exp + 1)) begin
                bad++;
                $display("FAIL rr_order[%0d]: got rr=%b res=%h addr=%h, need %b/%h/%h", r, bus_rr.resp_ready,
                         bus_rr.resp_result, bus_rr.mu_addr, 3'(1 << exp), 32'hA0 + r, 32'h100 * (exp + 1));
            end
            bus_rr.req_valid[exp] = 1'b0;
            cyc();
            bus_rr.req_valid[exp] = 1'b1;
        end
        bus_rr.req_valid = '0;
        cyc();
        cyc();
    endtask

    task automatic test_fixed_priority();
        bit ok;
        int exp;
        do_reset();
        for (int c = 0; c < 3; c++) set_req(1, c, 1'b1, 1'b0, 3'b010, 32'h100 * (c + 1), 32'h0);
        for (int r = 0; r < 3; r++) begin
            exp = 2 - r;
            serve(1, 2, 32'hB0 + r, ok);
            total++;
            if (!ok || bus_fp.resp_ready !== 3'(1 << exp) || bus_fp.resp_result !== 32'hB0 + r) begin
                bad++;
                $display("FAIL fp_order[%0d]: got ok=%b rr=%b res=%h, need 1/%b/%h", r, ok,
                         bus_fp.resp_ready, bus_fp.resp_result, 3'(1 << exp), 32'hB0 + r);
            end
            bus_fp.req_valid[exp] = 1'b0;
            cyc();
        end
        cyc();
    endtask

    task automatic test_flush_fetch();
        bit ok;
        do_reset();
        set_req(0, 0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        cyc();
        cyc();
        rob_clear = 1'b1;
        cyc();
        rob_clear = 1'b0;
        total++;
        if (bus_rr.mu_valid !== 1'b1 || bus_rr.mu_addr !== 32'h40) begin
            bad++;
            $display("FAIL flush_hold: got valid=%b addr=%h, need 1/00000040", bus_rr.mu_valid, bus_rr.mu_addr);
        end
        set_mu(0, 1'b1, 32'h1234);
        cyc();
        set_mu(0, 1'b0, 32'h0);
        total++;
        if (bus_rr.resp_ready !== 3'b000 || bus_rr.resp_result !== 32'h0 || bus_rr.mu_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_discard: got rr=%b res=%h valid=%b, need 000/0/0",
                     bus_rr.resp_ready, bus_rr.resp_result, bus_rr.mu_valid);
        end
        bus_rr.req_valid[0] = 1'b0;
        cyc();
        set_req(0, 1, 1'b1, 1'b0, 3'b010, 32'h2000, 32'h0);
        serve(0, 3, 32'h55AA, ok);
        total++;
        if (!ok || bus_rr.resp_ready !== 3'b010 || bus_rr.resp_result !== 32'h55AA) begin
            bad++;
            $display("FAIL flush_next: got ok=%b rr=%b res=%h, need 1/010/000055aa",
                     ok, bus_rr.resp_ready, bus_rr.resp_result);
        end
        bus_rr.req_valid[1] = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_flush_arb();
        bit ok;
        do_reset();
        set_req(0, 0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        set_req(0, 1, 1'b1, 1'b0, 3'b010, 32'h2000, 32'h0);
        rob_clear = 1'b1;
        cyc();
        rob_clear = 1'b0;
        bus_rr.req_valid[0] = 1'b0;
        total++;
        if (bus_rr.mu_valid !== 1'b1 || bus_rr.mu_addr !== 32'h2000) begin
            bad++;
            $display("FAIL flush_arb_win: got valid=%b addr=%h, need 1/00002000", bus_rr.mu_valid, bus_rr.mu_addr);
        end
        serve(0, 2, 32'h77, ok);
        total++;
        if (!ok || bus_rr.resp_ready !== 3'b010) begin
            bad++;
            $display("FAIL flush_arb_resp: got ok=%b rr=%b, need 1/010", ok, bus_rr.resp_ready);
        end
        bus_rr.req_valid[1] = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_flush_store();
        int chs [2] = '{1, 0};
        foreach (chs[k]) begin
            do_reset();
            set_req(0, chs[k], 1'b1, 1'b1, 3'b000, 32'h30000, 32'h41);
            cyc();
            for (int i = 0; i < 4; i++) begin
                total++;
                if (bus_rr.mu_valid !== 1'b1 || bus_rr.mu_wr !== 1'b1 || bus_rr.mu_value !== 32'h41 ||
                    bus_rr.mu_addr !== 32'h30000) begin
                    bad++;
                    $display("FAIL store_busy[ch%0d,%0d]: got valid=%b wr=%b val=%h addr=%h, need 1/1/41/30000",
                             chs[k], i, bus_rr.mu_valid, bus_rr.mu_wr, bus_rr.mu_value, bus_rr.mu_addr);
                end
                rob_clear = (i == 1);
                if (i == 3) set_mu(0, 1'b1, 32'h0);
                cyc();
            end
            set_mu(0, 1'b0, 32'h0);
            rob_clear = 1'b0;
            total++;
            if (bus_rr.resp_ready !== 3'(1 << chs[k])) begin
                bad++;
                $display("FAIL store_resp[ch%0d]: got rr=%b, need %b", chs[k], bus_rr.resp_ready, 3'(1 << chs[k]));
            end
            bus_rr.req_valid = '0;
            cyc();
            cyc();
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_req(0, 2, 1'b1, 1'b0, 3'b010, 32'h3000, 32'h0);
        cyc();
        cyc();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_mu(0, (i == 1), 32'hBAD);
            cyc();
            total++;
            if (bus_rr.mu_valid !== 1'b1 || bus_rr.mu_addr !== 32'h3000 || bus_rr.resp_ready !== 3'b000) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got valid=%b addr=%h rr=%b, need 1/00003000/000",
                         i, bus_rr.mu_valid, bus_rr.mu_addr, bus_rr.resp_ready);
            end
        end
        set_mu(0, 1'b0, 32'h0);
        rdy_in = 1'b1;
        cyc();
        cyc();
        set_mu(0, 1'b1, 32'hCAFE);
        total++;
        if (bus_rr.resp_ready !== 3'b000 || bus_rr.mu_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_early: got rr=%b valid=%b, need 000/1", bus_rr.resp_ready, bus_rr.mu_valid);
        end
        cyc();
        set_mu(0, 1'b0, 32'h0);
        total++;
        if (bus_rr.resp_ready !== 3'b100 || bus_rr.resp_result !== 32'hCAFE) begin
            bad++;
            $display("FAIL stall_done: got rr=%b res=%h, need 100/0000cafe", bus_rr.resp_ready, bus_rr.resp_result);
        end
        bus_rr.req_valid = '0;
        cyc();
        cyc();
    endtask

    task automatic test_reset_busy();
        bit ok;
        do_reset();
        set_req(0, 0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        cyc();
        cyc();
        rst_in = 1'b1;
        bus_rr.req_valid[0] = 1'b0;
        cyc();
        rst_in = 1'b0;
        total++;
        if (bus_rr.mu_valid !== 1'b0 || bus_rr.mu_len !== 3'b111 || bus_rr.mu_addr !== 32'h0 ||
            bus_rr.resp_ready !== 3'b000) begin
            bad++;
            $display("FAIL rst_busy_out: got valid=%b len=%b addr=%h rr=%b, need 0/111/0/000",
                     bus_rr.mu_valid, bus_rr.mu_len, bus_rr.mu_addr, bus_rr.resp_ready);
        end
        cyc();
        total++;
        if (bus_rr.mu_valid !== 1'b0 || bus_rr.resp_ready !== 3'b000) begin
            bad++;
            $display("FAIL rst_busy_idle: got valid=%b rr=%b, need 0/000", bus_rr.mu_valid, bus_rr.resp_ready);
        end
        set_req(0, 2, 1'b1, 1'b0, 3'b010, 32'h3000, 32'h0);
        cyc();
        total++;
        if (bus_rr.mu_valid !== 1'b1 || bus_rr.mu_addr !== 32'h3000) begin
            bad++;
            $display("FAIL rst_busy_grant: got valid=%b addr=%h, need 1/00003000", bus_rr.mu_valid, bus_rr.mu_addr);
        end
        serve(0, 2, 32'h99, ok);
        total++;
        if (!ok || bus_rr.resp_ready !== 3'b100 || bus_rr.resp_result !== 32'h99) begin
            bad++;
            $display("FAIL rst_busy_resp: got ok=%b rr=%b res=%h, need 1/100/00000099",
                     ok, bus_rr.resp_ready, bus_rr.resp_result);
        end
        bus_rr.req_valid = '0;
        cyc();
        cyc();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        rob_clear = 1'b0;
        bus_rr.req_valid = '0; bus_rr.req_wr = '0; bus_rr.req_len = '0;
        bus_rr.req_addr = '0;  bus_rr.req_value = '0;
        bus_rr.mu_ready = 1'b0; bus_rr.mu_result = '0;
        bus_fp.req_valid = '0; bus_fp.req_wr = '0; bus_fp.req_len = '0;
        bus_fp.req_addr = '0;  bus_fp.req_value = '0;
        bus_fp.mu_ready = 1'b0; bus_fp.mu_result = '0;
        cyc();
        test_reset();
        test_single_read();
        test_rr_fairness();
        test_fixed_priority();
        test_flush_fetch();
        test_flush_arb();
        test_flush_store();
        test_stall();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
